tiger_muldiv_unit: RTL and testbench
====================================

// Module: tiger_muldiv_unit
// PURPOSE
// Parametrised multiply/divide unit with architectural HI/LO registers for the tiger execute stage.
// Replaces fixed vendor mult/div cores and a free countdown with:
//   - a pipelined multiplier of configurable depth;
//   - an in-house iterative divider with configurable bits per cycle;
//   - an explicit FSM, done/busy status and defined divide-by-zero handling.
// Issues MULT/MULTU/DIV/DIVU/MTHI/MTLO, serves MFHI/MFLO, and requests a pipeline stall while results are pending.
// PARAMETERS
// DATA_W      32  operand/HI/LO width
// MUL_STAGES  3   multiplier pipeline depth (>=1); MULT latency in cycles
// DIV_UNROLL  1   quotient bits resolved per cycle; must divide DATA_W (1,2,4)
// PORTS
// clk          in   1        clock
// reset        in   1        async active-high reset
// stall        in   1        pipeline stall; no new op accepted while high
// op_valid     in   1        op field valid this cycle
// op           in   3        0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MFHI,7 MFLO
// rs           in   DATA_W   first operand (dividend / multiplicand / MTxx source)
// rt           in   DATA_W   second operand (divisor / multiplier)
// rd_data      out  DATA_W   HI (MFHI) or LO (MFLO), combinational from registers; else 0
// stall_rq     out  1        op_valid & op in {MFHI,MFLO} & busy
// busy         out  1        state != IDLE
// done         out  1        1-cycle pulse on the edge HI/LO take a MULT/DIV result
// div_by_zero  out  1        1-cycle pulse with done when a DIV/DIVU had rt==0
// hi, lo       out  DATA_W   architectural registers
// BEHAVIOUR
// Reset (async): state IDLE, hi=lo=0, counter=0, done=div_by_zero=0; in-flight op discarded.
// Accept: op_valid & !stall at rising edge. Ops not accepted when stall=1; in-flight ops keep running.
// FSM: IDLE -> MUL (MULT/MULTU), IDLE -> DIV (DIV/DIVU).
//   MUL: counter=MUL_STAGES-1, counts down; at 0 write hi/lo, pulse done, -> IDLE.
//   DIV: DATA_W/DIV_UNROLL iteration cycles, then FIX (sign correction) cycle; at FIX write, done, -> IDLE.
// Latency: MULT issue at edge N -> hi/lo valid after edge N+MUL_STAGES.
//   DIV -> valid after edge N+DATA_W/DIV_UNROLL+1 (33 for defaults).
// Restart: accepted MULT/DIV while busy aborts current op and starts new one (last issued wins); no done for aborted op.
// MTHI/MTLO: write rs to hi/lo at the accepting edge. If busy: abort op -> IDLE, other register unchanged.
// MFHI/MFLO while busy: stall_rq=1 until the edge after done; rd_data is then valid.
// Multiply: operands extended to DATA_W+1 bits (sign for MULT, zero for MULTU); {hi,lo} = low 2*DATA_W bits of product.
//   Operands registered at issue; pipeline free-running.
// Divide: restoring division on magnitudes (abs for DIV, raw for DIVU).
//   DIV signs: quotient sign = rs^rt sign bit; remainder takes dividend sign.
//   lo=quotient, hi=remainder.
//   DIV(-2^(W-1), -1): lo=0x80000000, hi=0 (falls out of magnitude algorithm; no trap).
//   rt==0 (either signedness): lo=all ones, hi=rs unchanged; div_by_zero pulse.
// Simultaneous: MF* with done on same edge: stall_rq already 0 is NOT allowed; busy drops on the done edge.
// No hi/lo write occurs outside accept, done, or reset.
// STRUCTURE
// Package tiger_muldiv_pkg: op encoding localparams, FSM state encoding (IDLE,MUL,DIV,FIX).
//   Package also holds helper function abs_w.
// Sub-module tiger_div_iter: magnitude restoring divider.
//   Interface: start, num, den, DIV_UNROLL bits/cycle; outputs quot, rem, last.
// Multiplier inline as MUL_STAGES register chain around a '*' (retiming left to synthesis).
// TESTING
// MULT rs=0xFFFFFFFE, rt=3 -> after 3 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same ops -> hi=2, lo=0xFFFFFFFA.
// DIV rs=-7, rt=2 -> edge 33: lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; done pulses once each.
// DIV rt=0, rs=0x1234 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 with done.
// Issue DIV, MFLO next cycle -> stall_rq held 33 cycles, rd_data=quotient when dropped; stall mid-div does not delay done.
// DIV 100/3 then MULT 5*6 at cycle 10 -> only MULT result (lo=30, hi=0), single done; MTHI 0xAA mid-DIV -> hi=0xAA, lo keeps old.
// Assert reset during DIV cycle 20 -> busy=0, hi=lo=0 immediately; next MULT 2*2 completes normally (lo=4).
```

Note: the "Simultaneous" rule in BEHAVIOUR is garbled and needs correcting before implementation. As written it says stall_rq being 0 on the done edge is "NOT allowed", which contradicts the MFHI/MFLO rule two lines above it. The intended requirement is:
- On the done edge, busy is still 1, so an MFHI/MFLO presented that cycle is stalled.
- MFHI/MFLO is served on the next cycle, when busy=0 and rd_data reflects the new hi/lo.

Source files
------------

// File: rtl/tiger_muldiv_pkg.sv
// Shared definitions for the tiger multiply/divide unit: op encoding, FSM states
// and the magnitude helper used on divide operands.
package tiger_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  localparam int ABS_MAX_W = 64;

  // Magnitude of a w-bit two's complement value held in the low bits of v.
  // The most negative value maps to its own unsigned magnitude (2^(w-1)).
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [ABS_MAX_W-1:0] mask;
    mask = (w >= ABS_MAX_W) ? '1 : ((ABS_MAX_W'(1) << w) - ABS_MAX_W'(1));
    if (((v >> (w - 1)) & ABS_MAX_W'(1)) != '0) abs_w = (-v) & mask;
    else abs_w = v & mask;
  endfunction

endpackage

// File: rtl/tiger_div_iter.sv
// Restoring divider on unsigned magnitudes; resolves UNROLL quotient bits per
// enabled cycle and flags the cycle that performs the final iteration.
module tiger_div_iter #(
  parameter int W      = 32,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         last
);

  localparam int ITERS = W / UNROLL;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITERS - 1);

  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  den_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    step_r;
  logic [W-1:0]  step_q;

  // quot_q doubles as the dividend shift register: its MSB feeds the remainder.
  always_comb begin
    step_q = quot_q;
    step_r = {1'b0, rem_q};
    for (int i = 0; i < UNROLL; i++) begin
      step_r = {step_r[W-1:0], step_q[W-1]};
      step_q = {step_q[W-2:0], 1'b0};
      if (step_r >= {1'b0, den_q}) begin
        step_r    = step_r - {1'b0, den_q};
        step_q[0] = 1'b1;
      end
    end
    quot_d = step_q;
    rem_d  = step_r[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      quot_q <= num;
      rem_q  <= '0;
      den_q  <= den;
      cnt_q  <= CNT_INIT;
    end else if (en) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign last = en & (cnt_q == '0);

endmodule

// File: rtl/tiger_muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO for the tiger execute stage:
// pipelined multiplier, iterative divider, and MF* stall request while busy.
module tiger_muldiv_unit
  import tiger_muldiv_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 3,
  parameter int DIV_UNROLL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] rd_data,
  output logic              stall_rq,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output state_e            dbg_state
);

  localparam int MCW = $clog2(MUL_STAGES + 1);
  localparam logic [MCW-1:0] MUL_INIT = MCW'(MUL_STAGES - 1);

  state_e              state_q;
  logic [MCW-1:0]      cnt_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                done_q, dbz_q;
  logic                div_neg_q, rem_neg_q, dz_q;
  logic [DATA_W-1:0]   dividend_q;
  logic [DATA_W:0]     mul_a_q, mul_b_q;
  logic [2*DATA_W-1:0] prod_c, mul_res;

  logic accept, is_mul_op, is_div_op, is_mt_op, takes_over, signed_op;
  logic [DATA_W-1:0] rs_mag, rt_mag, div_quot, div_rem, q_fix, r_fix;
  logic div_last;

  assign accept     = op_valid & ~stall;
  assign is_mul_op  = (op == OP_MULT) | (op == OP_MULTU);
  assign is_div_op  = (op == OP_DIV) | (op == OP_DIVU);
  assign is_mt_op   = (op == OP_MTHI) | (op == OP_MTLO);
  assign takes_over = accept & (is_mul_op | is_div_op | is_mt_op);
  assign signed_op  = (op == OP_MULT) | (op == OP_DIV);

  assign rs_mag = (op == OP_DIV) ? DATA_W'(abs_w(ABS_MAX_W'(rs), DATA_W)) : rs;
  assign rt_mag = (op == OP_DIV) ? DATA_W'(abs_w(ABS_MAX_W'(rt), DATA_W)) : rt;

  // Operands carry one extension bit so MULT and MULTU share a single multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else if (accept & is_mul_op) begin
      mul_a_q <= {signed_op & rs[DATA_W-1], rs};
      mul_b_q <= {signed_op & rt[DATA_W-1], rt};
    end
  end

  assign prod_c = {{(DATA_W-1){mul_a_q[DATA_W]}}, mul_a_q}
                * {{(DATA_W-1){mul_b_q[DATA_W]}}, mul_b_q};

  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_res = prod_c;
    end else begin : g_mul_pipe
      logic [2*DATA_W-1:0] pipe_q [MUL_STAGES-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= prod_c;
          for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign mul_res = pipe_q[MUL_STAGES-2];
    end
  endgenerate

  tiger_div_iter #(
    .W      (DATA_W),
    .UNROLL (DIV_UNROLL)
  ) u_div (
    .clk   (clk),
    .rst   (reset),
    .start (accept & is_div_op),
    .en    (state_q == ST_DIV),
    .num   (rs_mag),
    .den   (rt_mag),
    .quot  (div_quot),
    .rem   (div_rem),
    .last  (div_last)
  );

  assign q_fix = div_neg_q ? -div_quot : div_quot;
  assign r_fix = rem_neg_q ? -div_rem : div_rem;

  // Any accepted MULT/DIV/MTxx takes the FSM over; otherwise the current op advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      div_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      dividend_q <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (takes_over) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            state_q <= ST_MUL;
            cnt_q   <= MUL_INIT;
          end
          OP_DIV, OP_DIVU: begin
            state_q    <= ST_DIV;
            div_neg_q  <= signed_op & (rs[DATA_W-1] ^ rt[DATA_W-1]);
            rem_neg_q  <= signed_op & rs[DATA_W-1];
            dz_q       <= (rt == '0);
            dividend_q <= rs;
          end
          OP_MTHI: begin
            hi_q    <= rs;
            state_q <= ST_IDLE;
          end
          OP_MTLO: begin
            lo_q    <= rs;
            state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_MUL: begin
            if (cnt_q == '0) begin
              {hi_q, lo_q} <= mul_res;
              done_q       <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q - MCW'(1);
            end
          end
          ST_DIV: if (div_last) state_q <= ST_FIX;
          ST_FIX: begin
            if (dz_q) begin
              lo_q  <= '1;
              hi_q  <= dividend_q;
              dbz_q <= 1'b1;
            end else begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign stall_rq    = op_valid & ((op == OP_MFHI) | (op == OP_MFLO)) & busy;
  assign rd_data     = (op_valid & (op == OP_MFHI)) ? hi_q :
                       (op_valid & (op == OP_MFLO)) ? lo_q : '0;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tiger_muldiv_unit.sv
// Directed bench for tiger_muldiv_unit: hand-computed MULT/DIV results,
// latency, abort/restart, MT*/MF* behaviour and asynchronous reset.
module tb_tiger_muldiv_unit;
  import tiger_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, op_valid;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] rd_data, hi, lo;
  logic        stall_rq, busy, done, div_by_zero;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  tiger_muldiv_unit #(
    .DATA_W     (32),
    .MUL_STAGES (3),
    .DIV_UNROLL (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .op_valid    (op_valid),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd_data     (rd_data),
    .stall_rq    (stall_rq),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Presents one op for a single cycle; accepted at the posedge in between.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    op_valid = 1'b0; op = OP_MULT;
    #1;
  endtask

  task automatic mul_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int d0;
    d0 = done_cnt;
    issue(o, a, b);
    tick(2);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_early"}, done, 0);
    tick(1);
    check({tag, "_done"}, done, 1);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_idle"}, busy, 0);
    tick(1);
    check({tag, "_pulses"}, done_cnt - d0, 1);
  endtask

  task automatic div_case(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
    int d0;
    d0 = done_cnt;
    issue(o, a, b);
    tick(32);
    check({tag, "_fix"}, dbg_state, ST_FIX);
    check({tag, "_early"}, done, 0);
    tick(1);
    check({tag, "_done"}, done, 1);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_dbz"}, div_by_zero, edbz);
    check({tag, "_idle"}, busy, 0);
    tick(1);
    check({tag, "_pulses"}, done_cnt - d0, 1);
    check({tag, "_dbz_end"}, div_by_zero, 0);
  endtask

  initial begin
    int n, d0;
    reset = 1'b1; stall = 1'b0; op_valid = 1'b0; op = OP_MULT; rs = '0; rt = '0;
    tick(3);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    tick(1);
    check("rst_state", dbg_state, ST_IDLE);

    mul_case("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    mul_case("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    mul_case("mult_m1sq", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    mul_case("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul_case("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    div_case("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    div_case("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    div_case("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
    div_case("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 1'b0);
    div_case("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    div_case("div_by0", OP_DIV, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    div_case("divu_by0", OP_DIVU, 32'h8000_0005, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF, 1'b1);

    // MFLO right behind a DIV: stalled through the done edge, served the cycle after.
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd3;
    @(negedge clk);
    op = OP_MFLO;
    #1;
    n = 0;
    while (stall_rq === 1'b1 && n < 100) begin
      n++;
      if (n == 10) stall = 1'b1;
      if (n == 14) stall = 1'b0;
      @(negedge clk);
      #1;
    end
    check("mflo_stall_len", n, 33);
    check("mflo_rd_data", rd_data, 32'd33);
    check("mflo_done", done, 1);
    check("mflo_hi", hi, 32'd1);
    op_valid = 1'b0; op = OP_MULT;
    tick(1);

    // DIV aborted by MULT issued ten cycles later: only the MULT result lands.
    d0 = done_cnt;
    issue(OP_DIV, 32'd100, 32'd3);
    tick(8);
    issue(OP_MULT, 32'd5, 32'd6);
    tick(2);
    check("restart_busy", busy, 1);
    tick(1);
    check("restart_done", done, 1);
    check("restart_lo", lo, 32'd30);
    check("restart_hi", hi, 32'd0);
    tick(30);
    check("restart_pulses", done_cnt - d0, 1);
    check("restart_lo_end", lo, 32'd30);

    // MTLO while idle, then MTHI aborting a DIV.
    issue(OP_MTLO, 32'h55, 32'h0);
    check("mtlo_lo", lo, 32'h55);
    d0 = done_cnt;
    issue(OP_DIV, 32'd100, 32'd3);
    tick(4);
    issue(OP_MTHI, 32'hAA, 32'h0);
    check("mthi_hi", hi, 32'hAA);
    check("mthi_lo", lo, 32'h55);
    check("mthi_idle", busy, 0);
    tick(35);
    check("mthi_no_done", done_cnt - d0, 0);
    check("mthi_lo_end", lo, 32'h55);

    // rd_data selection while idle; stall held so nothing is accepted.
    stall = 1'b1; op_valid = 1'b1; op = OP_MFHI;
    #1;
    check("rd_mfhi", rd_data, 32'hAA);
    check("rd_mfhi_nostall", stall_rq, 0);
    op = OP_MFLO;
    #1;
    check("rd_mflo", rd_data, 32'h55);
    op = OP_DIVU;
    #1;
    check("rd_other", rd_data, 32'h0);
    op_valid = 1'b0;
    #1;
    stall = 1'b0;
    tick(1);
    check("stall_no_accept", busy, 0);

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'd100, 32'd3);
    tick(19);
    check("rst_mid_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    tick(1);
    reset = 1'b0;
    tick(1);
    mul_case("post_rst_mult", OP_MULT, 32'd2, 32'd2, 32'd0, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
